// File: rtl/stream_pkg.sv
// Shared types and default widths for the sequence stream blocks.
// State encoding is shared so monitors can decode checker state.
package stream_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    FAIL = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/stream_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/stream_seq_checker.sv
// Incrementing-counter stream checker: lock on first beat, count beats/errors.
// Define STREAM_SEQ_CHECK_RESYNC_EN to re-seed on mismatch instead of FAIL.
module stream_seq_checker
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  clr,
  input  logic                  ivalid,
  input  logic [DATA_WIDTH-1:0] idata,
  output logic                  locked,
  output logic                  fail,
  output logic                  err_pulse,
  output logic [DATA_WIDTH-1:0] exp_data,
  output logic [CNT_WIDTH-1:0]  rx_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  state_t                state;
  state_t                state_nx;
  logic [DATA_WIDTH-1:0] exp_nx;
  logic                  err_nx;
  logic                  beat;

  // clr wins over a coincident beat
  assign beat = ivalid & ~clr;

  always_comb begin
    state_nx = state;
    exp_nx   = exp_data;
    err_nx   = 1'b0;
    if (clr) begin
      state_nx = HUNT;
      exp_nx   = '0;
    end else if (ivalid) begin
      unique case (state)
        HUNT: begin
          exp_nx   = idata + DATA_WIDTH'(1);
          state_nx = LOCK;
        end
        LOCK: begin
          if (idata == exp_data) begin
            exp_nx = exp_data + DATA_WIDTH'(1);
          end else begin
            err_nx = 1'b1;
`ifdef STREAM_SEQ_CHECK_RESYNC_EN
            exp_nx = idata + DATA_WIDTH'(1);
`else
            state_nx = FAIL;
`endif
          end
        end
        FAIL: begin
          state_nx = FAIL;
        end
        default: begin
          state_nx = HUNT;
          exp_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= HUNT;
      exp_data  <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nx;
      exp_data  <= exp_nx;
      err_pulse <= err_nx;
      locked    <= (state_nx == LOCK);
      fail      <= (state_nx == FAIL);
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_rx_cnt (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .clr  (clr),
    .inc  (beat),
    .count(rx_cnt)
  );

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_err_cnt (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .clr  (clr),
    .inc  (err_nx),
    .count(err_cnt)
  );

endmodule

// File: doc/stream_seq_checker.md
# stream_seq_checker

Receiving end of the incrementing-counter stream: consumes the `ivalid`/`idata` beats produced by the sequence source and checks that each beat equals the previous beat plus one, modulo 2^DATA_WIDTH. Locks onto the first beat, then counts received beats and sequence errors. Status is registered for the bench and for on-chip monitors. Sits directly downstream of the source pipeline register in the basic simulation and loopback environments.

## Interface
- DATA_WIDTH, 8, beat width in bits.
- CNT_WIDTH, 16, width of the beat and error counters.
- sys_clk  input  1  system clock, rising edge.
- sys_rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous clear of counters and state, back to HUNT.
- ivalid  input  1  beat valid; no backpressure, every valid beat is consumed.
- idata  input  DATA_WIDTH  beat data.
- locked  output  1  high in LOCK state.
- fail  output  1  high in FAIL state (sticky error).
- err_pulse  output  1  one-cycle pulse per mismatched beat.
- exp_data  output  DATA_WIDTH  next expected value.
- rx_cnt  output  CNT_WIDTH  valid beats received since reset/clr, saturating.
- err_cnt  output  CNT_WIDTH  mismatches since reset/clr, saturating.

## Operation
- States:
  - HUNT (reset state).
  - LOCK.
  - FAIL.
- HUNT:
  - First valid beat seeds `exp_data <= idata+1` and moves to LOCK.
  - The seed beat is never an error.
- LOCK, valid beat with `idata == exp_data`: `exp_data <= exp_data+1` and stay in LOCK.
- LOCK, valid beat with `idata != exp_data`:
  - `err_pulse` fires and `err_cnt` increments.
  - Next state depends on configuration (see Configuration).
- FAIL:
  - Holds until `clr` or `sys_rst`.
  - Valid beats still increment `rx_cnt`.
  - No further compares, so no `err_pulse` and no `err_cnt` change.
- `rx_cnt` increments on every valid beat in every state.
- Arithmetic rules:
  - `exp_data` wraps modulo 2^DATA_WIDTH, so 255 -> 0 is a match at width 8.
  - Both counters saturate at all-ones and never wrap.
- Reset values of all outputs:
  - `locked = 0`, `fail = 0`, `err_pulse = 0`.
  - `exp_data = 0`, `rx_cnt = 0`, `err_cnt = 0`.
  - State is HUNT.
- `clr`: next cycle all outputs take their reset values and state is HUNT.
- `clr` together with `ivalid`: `clr` wins and the beat is discarded; it neither seeds nor counts.
- `sys_rst` asserted mid-stream: outputs clear immediately, asynchronously. The first valid beat after release re-seeds.
- Gaps (`ivalid` low) carry no meaning; expectation holds across any idle interval.

## Timing
- Every output is a flop.
- All effects of a beat sampled at edge N are visible after edge N:
  - `locked`, `fail`, `exp_data`, `rx_cnt`, `err_cnt` update.
  - `err_pulse` is high for exactly the cycle following edge N.
- Latency is one cycle. Throughput is one beat per cycle.
- Back-to-back mismatches in LOCK (resync build): one `err_pulse` per beat, so `err_pulse` can stay high across consecutive cycles.
- Beats with `ivalid` high during `sys_rst` are ignored.

## Configuration
- Macro: `STREAM_SEQ_CHECK_RESYNC_EN`.
- Defined (resync build):
  - A mismatch in LOCK stays in LOCK and re-seeds with `exp_data <= idata+1`.
  - A single dropped beat costs exactly one error.
  - FAIL is unreachable and `fail` stays 0.
- Undefined (default):
  - A mismatch in LOCK goes to FAIL.
  - `locked` drops and `fail` rises on the same edge.
  - `exp_data` freezes at its pre-error value.

## Structure
- Shared package `stream_pkg` holds:
  - State encoding constants (HUNT=2'd0, LOCK=2'd1, FAIL=2'd2).
  - Default widths (DATA_WIDTH=8, CNT_WIDTH=16).
- Sub-module `sat_counter`, parameterised by width, with inputs `inc` and `clr`, used for both `rx_cnt` and `err_cnt`.
- The FSM and compare logic stay in the top module.

## Test plan
- After reset release, feed 0,1,2…9, one beat per cycle -> `locked` high after the first beat, `rx_cnt = 10`, `err_cnt = 0`, `exp_data = 10`.
- Seed at 250 and run to 260 mod 256 (250…255,0…4) -> no `err_pulse` across the 255->0 wrap; `exp_data = 5`.
- Feed 0,1,2,4,5, default build -> one `err_pulse` after the beat 4, `fail = 1`, `locked = 0`, `exp_data = 3`, `err_cnt = 1`, `rx_cnt = 5`. Resync build -> `err_cnt = 1`, `locked = 1`, `exp_data = 6`.
- Feed 0..3 with random gaps of 0-5 idle cycles -> no errors; `rx_cnt = 4`.
- Assert `clr` in the same cycle as beat 7 while locked -> next cycle HUNT, all counters 0; the following beat 8 re-seeds with no error and `exp_data = 9`.
- Pulse `sys_rst` mid-stream between clock edges -> outputs clear asynchronously, before the next edge; the stream resumes at 40 with no error.
